// File: rtl/vga_ram_arbiter.sv
// Shares one single-port pixel RAM between the display scan (always wins) and a
// blanking-time pixel writer; display data and syncs leave re-aligned by 3 cycles.
module vga_ram_arbiter #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned H_ACT  = 800,
  parameter int unsigned V_ACT  = 600
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              Ready_Sig,
  input  logic              HSYNC_Sig,
  input  logic              VSYNC_Sig,
  input  logic [10:0]       Column_Addr_Sig,
  input  logic [10:0]       Row_Addr_Sig,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] PixLimit = ADDR_W'(H_ACT * V_ACT);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state;
  logic [2:0]        rdy_dly;
  logic [2:0]        hs_dly;
  logic [2:0]        vs_dly;
  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;
  logic [ADDR_W-1:0] disp_addr;
  logic              in_range;

  assign row_w    = ADDR_W'(Row_Addr_Sig);
  assign col_w    = ADDR_W'(Column_Addr_Sig);
  assign in_range = (wr_addr < PixLimit);

  // 800 = 512 + 256 + 32, so the default width needs only shifts and adds.
  always_comb begin
    disp_addr = '0;
    if (H_ACT == 800) begin
      disp_addr = (row_w << 9) + (row_w << 8) + (row_w << 5) + col_w;
    end else begin
      disp_addr = row_w * ADDR_W'(H_ACT) + col_w;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      rdy_dly     <= '0;
      hs_dly      <= '0;
      vs_dly      <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      if (Ready_Sig) begin
        state    <= StRead;
        ram_addr <= disp_addr;
        ram_we   <= 1'b0;
        wr_ack   <= 1'b0;
        wr_err   <= 1'b0;
      end else if (wr_req && (state != StWrite)) begin
        // Out-of-range writes are still acked so the writer never stalls.
        state     <= StWrite;
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
        ram_we    <= in_range;
        wr_ack    <= 1'b1;
        wr_err    <= ~in_range;
      end else begin
        state  <= StIdle;
        ram_we <= 1'b0;
        wr_ack <= 1'b0;
        wr_err <= 1'b0;
      end

      rdy_dly <= {rdy_dly[1:0], Ready_Sig};
      hs_dly  <= {hs_dly[1:0], HSYNC_Sig};
      vs_dly  <= {vs_dly[1:0], VSYNC_Sig};
      // rdy_dly[1] is the Ready_Sig that launched the read now on ram_rdata.
      pix_data    <= rdy_dly[1] ? ram_rdata : '0;
      frame_start <= vs_dly[0] & ~VSYNC_Sig;
    end
  end

  assign pix_valid = rdy_dly[2];
  assign hsync_o   = hs_dly[2];
  assign vsync_o   = vs_dly[2];

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Bench for vga_ram_arbiter: per-cycle vector table for the RAM side plus a queue
// scoreboard for the 3-cycle display pipeline, and a reset-mid-handshake sequence.
`timescale 1ns/1ps
module tb_vga_ram_arbiter;

  logic        vga_clk = 1'b0;
  logic        rst_n;
  logic        Ready_Sig, HSYNC_Sig, VSYNC_Sig;
  logic [10:0] Column_Addr_Sig, Row_Addr_Sig;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack, wr_err;
  logic [18:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] pix_data;
  logic        pix_valid, hsync_o, vsync_o, frame_start;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rdy, hs, vs;
    int          row, col;
    logic        req;
    int          wa;
    logic [15:0] wd;
    int          ea;
    logic [15:0] ew;
    logic        we, ack, err, fs;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        hs, vs;
  } pix_t;

  vec_t vecs[$];
  pix_t sb[$];

  vga_ram_arbiter dut (
    .vga_clk         (vga_clk),
    .rst_n           (rst_n),
    .Ready_Sig       (Ready_Sig),
    .HSYNC_Sig       (HSYNC_Sig),
    .VSYNC_Sig       (VSYNC_Sig),
    .Column_Addr_Sig (Column_Addr_Sig),
    .Row_Addr_Sig    (Row_Addr_Sig),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .wr_err          (wr_err),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .ram_rdata       (ram_rdata),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o),
    .frame_start     (frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  // Contents of the synchronous RAM model: a fixed pattern with one known pixel.
  function automatic logic [15:0] rd_val(input int a);
    return (a == 1605) ? 16'hABCD : (16'(a) ^ 16'hC3A5);
  endfunction

  always_ff @(posedge vga_clk) ram_rdata <= rd_val(int'(ram_addr));

  function automatic vec_t mk(input logic rdy, input logic hs, input logic vs, input int row,
                              input int col, input logic req, input int wa, input logic [15:0] wd,
                              input int ea, input logic [15:0] ew, input logic we,
                              input logic ack, input logic err, input logic fs);
    vec_t v;
    v.rdy = rdy; v.hs = hs; v.vs = vs; v.row = row; v.col = col; v.req = req;
    v.wa = wa; v.wd = wd; v.ea = ea; v.ew = ew; v.we = we; v.ack = ack; v.err = err;
    v.fs = fs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic prefill();
    pix_t z;
    z.valid = 1'b0; z.data = '0; z.hs = 1'b0; z.vs = 1'b0;
    sb.delete();
    sb.push_back(z);
    sb.push_back(z);
  endtask

  // Drive one cycle, then compare the RAM side and the pixel leaving the pipeline.
  task automatic step(input vec_t v, input int idx);
    pix_t p;
    Ready_Sig       = v.rdy;
    HSYNC_Sig       = v.hs;
    VSYNC_Sig       = v.vs;
    Row_Addr_Sig    = 11'(v.row);
    Column_Addr_Sig = 11'(v.col);
    wr_req          = v.req;
    wr_addr         = 19'(v.wa);
    wr_data         = v.wd;
    p.valid = v.rdy;
    p.data  = v.rdy ? rd_val(v.ea) : 16'h0;
    p.hs    = v.hs;
    p.vs    = v.vs;
    sb.push_back(p);
    @(posedge vga_clk);
    #1;
    check($sformatf("s%0d ram_addr", idx), 32'(ram_addr), 32'(v.ea));
    check($sformatf("s%0d ram_wdata", idx), 32'(ram_wdata), 32'(v.ew));
    check($sformatf("s%0d ram_we", idx), 32'(ram_we), 32'(v.we));
    check($sformatf("s%0d wr_ack", idx), 32'(wr_ack), 32'(v.ack));
    check($sformatf("s%0d wr_err", idx), 32'(wr_err), 32'(v.err));
    check($sformatf("s%0d frame_start", idx), 32'(frame_start), 32'(v.fs));
    p = sb.pop_front();
    check($sformatf("s%0d pix_valid", idx), 32'(pix_valid), 32'(p.valid));
    check($sformatf("s%0d pix_data", idx), 32'(pix_data), 32'(p.data));
    check($sformatf("s%0d hsync_o", idx), 32'(hsync_o), 32'(p.hs));
    check($sformatf("s%0d vsync_o", idx), 32'(vsync_o), 32'(p.vs));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, " ram_we"}, 32'(ram_we), 32'd0);
    check({tag, " wr_ack"}, 32'(wr_ack), 32'd0);
    check({tag, " wr_err"}, 32'(wr_err), 32'd0);
    check({tag, " pix_data"}, 32'(pix_data), 32'd0);
    check({tag, " pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, " hsync_o"}, 32'(hsync_o), 32'd0);
    check({tag, " vsync_o"}, 32'(vsync_o), 32'd0);
    check({tag, " frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Active scan: 2*800+5 = 1605, then the last pixel of the frame.
    vecs.push_back(mk(1, 1, 1, 2, 5, 0, 0, 16'h0, 1605, 16'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 6, 0, 0, 16'h0, 1606, 16'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 599, 799, 0, 0, 16'h0, 479999, 16'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 479999, 16'h0, 0, 0, 0, 0));
    // Back-to-back requests in blanking: acks only on alternating cycles.
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 100, 16'h1111, 100, 16'h1111, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 101, 16'h2222, 100, 16'h1111, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 101, 16'h2222, 101, 16'h2222, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 102, 16'h3333, 101, 16'h2222, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 102, 16'h3333, 102, 16'h3333, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 103, 16'h4444, 102, 16'h3333, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 103, 16'h4444, 102, 16'h3333, 0, 0, 0, 0));
    // Request held through 10 active cycles; serviced on the first blanking edge.
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(1, 1, 1, 1, k, 1, 200, 16'h5555, 800 + k, 16'h3333, 0, 0, 0, 0));
    end
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 200, 16'h5555, 200, 16'h5555, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 200, 16'h5555, 200, 16'h5555, 0, 0, 0, 0));
    // Range limit: 480000 is dropped with an error, 479999 is written.
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 480000, 16'h6666, 480000, 16'h6666, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 480000, 16'h6666, 480000, 16'h6666, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 479999, 16'h7777, 479999, 16'h7777, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 479999, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 100, 0, 0, 16'h0, 100, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 599, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    // Frame boundary: single frame_start on the first edge that sees VSYNC low.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 479200, 16'h7777, 0, 0, 0, 0));
    // Ready and request together: read wins, write follows on the next blank cycle.
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 300, 16'h8888, 800, 16'h7777, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 300, 16'h8888, 300, 16'h8888, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 16'h0, 801, 16'h8888, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 801, 16'h8888, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 801, 16'h8888, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 50, 16'h9999, 50, 16'h9999, 1, 1, 0, 0));

    rst_n = 1'b0;
    Ready_Sig = 1'b0; HSYNC_Sig = 1'b0; VSYNC_Sig = 1'b0;
    Row_Addr_Sig = '0; Column_Addr_Sig = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    prefill();

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Last vector left wr_ack high: reset must clear everything without a clock.
    check("pre-reset wr_ack", 32'(wr_ack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge vga_clk);
    #1;
    check_all_zero("held reset");
    rst_n = 1'b1;
    prefill();
    step(mk(0, 1, 1, 0, 0, 1, 50, 16'h9999, 50, 16'h9999, 1, 1, 0, 0), 100);
    step(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 50, 16'h9999, 0, 0, 0, 0), 101);
    step(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 50, 16'h9999, 0, 0, 0, 0), 102);
    step(mk(1, 0, 1, 0, 7, 0, 0, 16'h0, 7, 16'h9999, 0, 0, 0, 0), 103);
    step(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 7, 16'h9999, 0, 0, 0, 0), 104);
    step(mk(0, 1, 1, 0, 0, 0, 0, 16'h0, 7, 16'h9999, 0, 0, 0, 0), 105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_ram_arbiter.md
# vga_ram_arbiter

Shares one single-port synchronous pixel RAM between two requesters: the 800x600@60 display scan and a pixel writer such as a drawing engine or a loader. It sits between `vga_sync_module_800_600_60` and the RAM. Display reads always win and issue every cycle `Ready_Sig` is high. Writer requests are serviced with a req/ack handshake only during blanking. Pixel data and sync signals leave the block re-aligned by a fixed pipeline delay.

## Interface
- `ADDR_W`, 19: RAM address width; must hold 480000 words.
- `DATA_W`, 16: pixel width (RGB565).
- `H_ACT`, 800: active pixels per line; the linear-address multiplier.
- `V_ACT`, 600: active lines; sets the write range limit `H_ACT*V_ACT`.
- `vga_clk` in 1: single clock, 40.0 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `Ready_Sig` in 1: active-region flag from the sync module.
- `HSYNC_Sig` in 1: horizontal sync from the sync module.
- `VSYNC_Sig` in 1: vertical sync from the sync module.
- `Column_Addr_Sig` in 11: active x, 0..799; valid when `Ready_Sig`=1.
- `Row_Addr_Sig` in 11: active y, 0..599; valid when `Ready_Sig`=1.
- `wr_req` in 1: writer request; `wr_addr` and `wr_data` must be stable while it is high.
- `wr_addr` in `ADDR_W`: linear write address.
- `wr_data` in `DATA_W`: write pixel.
- `wr_ack` out 1: one-cycle pulse; the write was accepted.
- `wr_err` out 1: one-cycle pulse together with `wr_ack`; address out of range, write dropped.
- `ram_addr` out `ADDR_W`: registered RAM address.
- `ram_wdata` out `DATA_W`: registered RAM write data.
- `ram_we` out 1: registered RAM write enable.
- `ram_rdata` in `DATA_W`: RAM read data, valid one cycle after the address edge.
- `pix_data` out `DATA_W`: display pixel; 0 whenever `pix_valid`=0.
- `pix_valid` out 1: `Ready_Sig` delayed 3 cycles.
- `hsync_o` out 1: `HSYNC_Sig` delayed 3 cycles.
- `vsync_o` out 1: `VSYNC_Sig` delayed 3 cycles.
- `frame_start` out 1: one-cycle pulse on each falling edge of `VSYNC_Sig`, registered.

## Operation
- **Reset.** All outputs and internal registers reset to 0, and the state machine resets to IDLE. This applies at any time, including mid-frame or mid-handshake. A request pending at reset is not acked; the writer keeps `wr_req` high and is serviced after reset is released.
- **Display address.** Linear address = `Row_Addr_Sig*H_ACT + Column_Addr_Sig`, computed as `(row<<9)+(row<<8)+(row<<5)+col` for the default `H_ACT`. It is computed in `ADDR_W` bits with no overflow, since the maximum is 479999.
- **Per-cycle decision**, sampled on each `vga_clk` edge, in priority order:
  1. READ: `Ready_Sig`=1. Drive `ram_addr` with the display address and `ram_we`=0. Any pending write waits.
  2. WRITE: `Ready_Sig`=0, `wr_req`=1, and the previous state was not WRITE. Drive `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`, and pulse `wr_ack`. Drive `ram_we`=1 only if `wr_addr` < `H_ACT*V_ACT`; otherwise drive `ram_we`=0 and pulse `wr_err`.
  3. IDLE: otherwise. `ram_we`=0; `ram_addr` and `ram_wdata` hold their last values.
- **Writer rate.** WRITE never follows WRITE; the cycle after WRITE is always READ or IDLE. The writer therefore gets at most one write per 2 cycles and has one cycle to present the next request after `wr_ack`.
- **State transitions.**
  - IDLE→READ and WRITE→READ when `Ready_Sig`=1.
  - READ→WRITE and IDLE→WRITE per rule 2.
  - WRITE→IDLE when `Ready_Sig`=0, whatever `wr_req` is.
- **Simultaneous events.** `Ready_Sig` rising in the same cycle as `wr_req` selects READ, and the write is deferred. A write is never aborted once acked. Collisions are impossible because exactly one operation is issued per cycle.
- **Starvation.** A `wr_req` held during the active region waits until the next blanking cycle. The worst case is one active line, 800 cycles.
- **Display data.** `pix_data` = `ram_rdata` registered, gated to 0 when the delayed `Ready_Sig` is 0.

## Timing
- Cycle n: `Ready_Sig`/address sampled.
- Edge n+1: `ram_addr` registered.
- Edge n+2: RAM registers its output; `ram_rdata` valid.
- Edge n+3: `pix_data` registered.
- `pix_valid`, `hsync_o` and `vsync_o` use 3-stage delay lines, so they stay aligned with `pix_data`.
- `wr_ack`, `wr_err` and `ram_we` assert on the same edge as the write address. The write is committed in the RAM at the following edge.
- `frame_start` asserts 1 cycle after the `VSYNC_Sig` falling edge is sampled, i.e. on the edge after `VSYNC_Sig` is first sampled 0 following a 1.
- No combinational path from any input to any output.

## Test plan
- **Active scan.** Drive `Ready_Sig`=1 with row=2, col=5.
  - `ram_addr`=1605 and `ram_we`=0 one edge later.
  - With `ram_rdata`=16'hABCD returned, `pix_data`=16'hABCD and `pix_valid`=1 3 edges after the sample.
- **Blanking writes.** Hold `wr_req`=1 continuously with `Ready_Sig`=0 for 6 cycles.
  - Exactly 3 `wr_ack` pulses, on alternating cycles.
  - Each pulse coincides with `ram_we`=1, `ram_addr`=`wr_addr` and `ram_wdata`=`wr_data`.
- **Request during active region.** Raise `wr_req` while `Ready_Sig`=1 for 10 cycles.
  - No `wr_ack` and `ram_we`=0 throughout.
  - `wr_ack` on the first edge after `Ready_Sig` falls.
- **Out-of-range write.** `wr_addr`=480000 in blanking.
  - `wr_ack`=1 and `wr_err`=1 for one cycle; `ram_we`=0.
- **Frame boundary.** Drive `VSYNC_Sig` 1→0.
  - A single `frame_start` pulse 1 cycle later.
  - `vsync_o` falls 3 cycles after `VSYNC_Sig`.
- **Reset mid-handshake.** Assert `rst_n`=0 during a `wr_ack` cycle.
  - All outputs go to 0 immediately (asynchronously).
  - After release, with `wr_req` still high and `Ready_Sig`=0, `wr_ack` is issued on the first edge.
